// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: miss-handshake
// states, the IF/ID bubble encoding and architectural constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_WAIT = 2'd1,
    ST_MISS_DONE = 2'd2
  } stall_state_e;

  localparam logic [31:0] NOP_INST = 32'hFC00_0000;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          TIMER_W  = 8;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges dcache miss
// stalls, load-use hazards and ID-stage redirects into one prioritised control set.
module pipe_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             redirect_i,
  input  logic             dc_miss_i,
  input  logic             dc_ack_i,
  output logic             pc_write_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             mem_stall_o,
  output logic             miss_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MISS_TIMEOUT);

  stall_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pend_q, pend_d;
  logic               timeout_q, timeout_d;
  logic               hz;
  logic               stall_raw;

  // Raw conditions; the outputs below gate them with reset and priority.
  always_comb begin
    hz = idex_memread_i && (idex_rt_i != REG_ZERO) &&
         ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    stall_raw = ((state_q == ST_IDLE) && dc_miss_i) || (state_q == ST_MISS_WAIT);
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    mem_stall_o   = 1'b0;
    if (rst_i) begin
      if (stall_raw) begin
        mem_stall_o = 1'b1;
        pc_write_o  = 1'b0;
      end else if (hz) begin
        ifid_hold_o   = 1'b1;
        idex_bubble_o = 1'b1;
        pc_write_o    = 1'b0;
      end else if (redirect_i || pend_q) begin
        ifid_flush_o = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    pend_d    = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (dc_miss_i) state_d = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        if (dc_ack_i) begin
          state_d = ST_MISS_DONE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_VAL) begin
          // No self-recovery: keep waiting for the ack, flag stays sticky.
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_MISS_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (mem_stall_o && redirect_i) begin
      pend_d = 1'b1;
    end else if (ifid_flush_o) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
    end
  end

  assign miss_timeout_o = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .inc_i  (mem_stall_o || ifid_hold_o),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .inc_i  (ifid_flush_o),
    .cnt_o  (flush_cnt_o)
  );

endmodule
